// File: rtl/i2osp_pkg.sv
// Shared types and helpers for the I2OSP octet-stream converter.
//   state_e   : controller states (idle, range check, streaming, reject pulse)
//   len_width : width of an octet-count field able to hold 0..width/8
package i2osp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StStream,
        StErr
    } state_e;

    function automatic int unsigned len_width(input int unsigned width);
        return $clog2(width / 8 + 1);
    endfunction

endpackage

// File: rtl/i2osp_stream_if.sv
// Request/response bundle for i2osp_stream.
//   in_valid/in_ready/x/xlen            : conversion request handshake
//   out_valid/out_ready/out_data/keep/last : octet-stream beats, first octet in top lane
//   err                                 : one-cycle reject pulse
// Modports: master = requester/consumer side, slave = converter side.
interface i2osp_stream_if #(
    parameter int unsigned WIDTH = 2048,
    parameter int unsigned BPB   = 1
);
    import i2osp_pkg::*;

    localparam int unsigned LEN_W = len_width(WIDTH);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     x;
    logic [LEN_W-1:0]     xlen;
    logic                 out_valid;
    logic                 out_ready;
    logic [8*BPB-1:0]     out_data;
    logic [BPB-1:0]       out_keep;
    logic                 out_last;
    logic                 err;

    modport master (
        output in_valid, x, xlen, out_ready,
        input  in_ready, out_valid, out_data, out_keep, out_last, err
    );

    modport slave (
        input  in_valid, x, xlen, out_ready,
        output in_ready, out_valid, out_data, out_keep, out_last, err
    );

endinterface

// File: rtl/i2osp_range_check.sv
// Combinational validity check for an I2OSP request.
//   x    : integer to convert
//   xlen : requested octet-string length
//   bad  : 1 when xlen is zero, longer than the word, or x does not fit in xlen octets
module i2osp_range_check
    import i2osp_pkg::*;
#(
    parameter  int unsigned WIDTH = 2048,
    localparam int unsigned LEN_W = len_width(WIDTH)
) (
    input  logic [WIDTH-1:0] x,
    input  logic [LEN_W-1:0] xlen,
    output logic             bad
);
    localparam int unsigned NOCT = WIDTH / 8;

    always_comb begin
        bad = (xlen == '0) || (xlen > LEN_W'(NOCT));
        // Any nonzero octet at or above position xlen means x >= 256^xlen.
        for (int unsigned i = 0; i < NOCT; i++) begin
            if ((LEN_W'(i) >= xlen) && (|x[8*i +: 8])) begin
                bad = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2osp_stream.sv
// I2OSP converter: turns a nonnegative integer into a big-endian octet string of
// the requested length and streams it out BPB octets per beat.
//   clk, reset : clock, synchronous active-high reset
//   bus        : request / octet-stream bundle (slave side)
module i2osp_stream
    import i2osp_pkg::*;
#(
    parameter int unsigned WIDTH = 2048,
    parameter int unsigned BPB   = 1
) (
    input logic           clk,
    input logic           reset,
    i2osp_stream_if.slave bus
);
    localparam int unsigned LEN_W = len_width(WIDTH);
    localparam int unsigned NOCT  = WIDTH / 8;
    localparam int unsigned DW    = 8 * BPB;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] word_q;
    logic [LEN_W-1:0] rem_q;    // octets not yet loaded into the output register
    logic             valid_q;
    logic [DW-1:0]    data_q;
    logic [BPB-1:0]   keep_q;
    logic             last_q;

    logic             bad;
    logic             accept;
    logic             beat_done;
    logic             load_beat;
    logic [DW-1:0]    beat_data;
    logic [BPB-1:0]   beat_keep;
    logic             beat_last;
    logic [LEN_W-1:0] beat_octs;
    logic [LEN_W+2:0] align_sh;

    i2osp_range_check #(
        .WIDTH (WIDTH)
    ) u_range_check (
        .x    (word_q),
        .xlen (rem_q),
        .bad  (bad)
    );

    assign accept    = bus.in_valid && (state_q == StIdle);
    assign beat_done = valid_q && bus.out_ready;
    // Refill the output register when it is empty or being drained this cycle.
    assign load_beat = (state_q == StStream) && (rem_q != '0) && (!valid_q || bus.out_ready);
    // One-time shift that puts the first octet of the string at the top of the word.
    assign align_sh  = {LEN_W'(NOCT) - rem_q, 3'b000};

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (bus.in_valid) state_d = StCheck;
            StCheck:  state_d = bad ? StErr : StStream;
            StStream: if (beat_done && last_q) state_d = StIdle;
            StErr:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        beat_data = '0;
        beat_keep = '0;
        for (int unsigned j = 0; j < BPB; j++) begin
            if (LEN_W'(j) < rem_q) begin
                beat_keep[BPB-1-j]         = 1'b1;
                beat_data[DW-1-8*j -: 8]   = word_q[WIDTH-1-8*j -: 8];
            end
        end
        beat_last = (rem_q <= LEN_W'(BPB));
        beat_octs = beat_last ? rem_q : LEN_W'(BPB);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            word_q  <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                word_q <= bus.x;
                rem_q  <= bus.xlen;
            end else if ((state_q == StCheck) && !bad) begin
                word_q <= word_q << align_sh;
            end else if (load_beat) begin
                word_q <= word_q << DW;
                rem_q  <= rem_q - beat_octs;
            end
            if (load_beat) begin
                valid_q <= 1'b1;
                data_q  <= beat_data;
                keep_q  <= beat_keep;
                last_q  <= beat_last;
            end else if (beat_done) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                keep_q  <= '0;
                last_q  <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_keep  = keep_q;
    assign bus.out_last  = last_q;
    assign bus.err       = (state_q == StErr);

endmodule

// File: tb/tb_i2osp_stream.sv
// Bench for i2osp_stream: two instances (1 and 4 octets per beat, 64-bit word),
// table-driven directed requests, hand-written stall/reset sequences and
// randomized requests checked against an octet-level reference model.
module tb_i2osp_stream;
    import i2osp_pkg::*;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        int          sel;
        logic [63:0] x;
        int          len;
        bit          err;
        int          nb;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    i2osp_stream_if #(.WIDTH(64), .BPB(1)) if1 ();
    i2osp_stream_if #(.WIDTH(64), .BPB(4)) if4 ();

    i2osp_stream #(.WIDTH(64), .BPB(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    i2osp_stream #(.WIDTH(64), .BPB(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));

    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    int    err_cnt [2];
    int    first_v [2] = '{-1, -1};
    bit    hv [2];
    logic [63:0] hd [2];
    logic [7:0]  hk [2];
    logic        hl [2];
    beat_t got0 [$];
    beat_t got1 [$];
    beat_t exp_q [$];
    bit    manual = 1'b0;
    bit    rnd_rdy = 1'b0;
    vec_t  tbl [12];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Consumer ready: always high, or random when rnd_rdy is set.
    always @(posedge clk) begin
        #1;
        if (!manual) begin
            if1.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if4.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic mon(input int s, input logic v, input logic r, input logic [63:0] d,
                       input logic [7:0] k, input logic l, input logic e);
        beat_t b;
        if (e) err_cnt[s]++;
        if (v && first_v[s] < 0) first_v[s] = cyc;
        if (v && hv[s]) begin
            check("hold_data", d, hd[s]);
            check("hold_keep_last", 64'({k, l}), 64'({hk[s], hl[s]}));
        end
        hv[s] = v && !r;
        hd[s] = d;
        hk[s] = k;
        hl[s] = l;
        if (v && r) begin
            b.data = d;
            b.keep = k;
            b.last = l;
            if (s == 0) got0.push_back(b);
            else        got1.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        mon(0, if1.out_valid, if1.out_ready, 64'(if1.out_data), 8'(if1.out_keep),
            if1.out_last, if1.err);
        mon(1, if4.out_valid, if4.out_ready, 64'(if4.out_data), 8'(if4.out_keep),
            if4.out_last, if4.err);
    end

    function automatic bit model_err(input logic [63:0] xv, input int len);
        if (len == 0 || len > 8) return 1'b1;
        if (len == 8) return 1'b0;
        return (xv >> (8 * len)) != 64'd0;
    endfunction

    // Octet k of the string is x / 256^(len-1-k) mod 256; lanes fill MSB first.
    task automatic build_exp(input int bpb, input logic [63:0] xv, input int len);
        int    nb;
        int    k;
        beat_t b;
        exp_q.delete();
        nb = (len + bpb - 1) / bpb;
        for (int bi = 0; bi < nb; bi++) begin
            b = '0;
            for (int j = 0; j < bpb; j++) begin
                k = bi * bpb + j;
                if (k < len) begin
                    b.keep[bpb-1-j] = 1'b1;
                    b.data[8*(bpb-1-j) +: 8] = 8'(xv >> (8 * (len - 1 - k)));
                end
            end
            b.last = (bi == nb - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic drive(input int s, input logic v, input logic [63:0] xv, input int len);
        if (s == 0) begin
            if1.in_valid = v;
            if1.x        = xv;
            if1.xlen     = 4'(len);
        end else begin
            if4.in_valid = v;
            if4.x        = xv;
            if4.xlen     = 4'(len);
        end
    endtask

    function automatic logic get_rdy(input int s);
        return (s == 0) ? if1.in_ready : if4.in_ready;
    endfunction

    task automatic start_req(input int s, input logic [63:0] xv, input int len,
                             input string tag, output int t_acc);
        if (s == 0) got0.delete();
        else        got1.delete();
        err_cnt[s] = 0;
        first_v[s] = -1;
        check({tag, "_in_ready"}, 64'(get_rdy(s)), 64'd1);
        drive(s, 1'b1, xv, len);
        @(posedge clk);
        #1;
        t_acc = cyc;
        drive(s, 1'b0, 64'd0, 0);
        check({tag, "_busy"}, 64'(get_rdy(s)), 64'd0);
    endtask

    task automatic finish_req(input int s, input logic [63:0] xv, input int len,
                              input bit exp_err, input int exp_nb, input string tag,
                              input int t_acc);
        int    n;
        beat_t g [$];
        n = 0;
        while (!get_rdy(s) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_done"}, 64'(n < 300), 64'd1);
        if (s == 0) g = got0;
        else        g = got1;
        check({tag, "_err"}, 64'(err_cnt[s]), 64'(exp_err));
        check({tag, "_nbeats"}, 64'(g.size()), 64'(exp_nb));
        if (exp_err) begin
            check({tag, "_err_turn"}, 64'(n), 64'd2);
        end else begin
            check({tag, "_latency"}, 64'(first_v[s] - t_acc), 64'd2);
            build_exp((s == 0) ? 1 : 4, xv, len);
            for (int i = 0; i < exp_q.size() && i < g.size(); i++) begin
                check({tag, "_data"}, g[i].data, exp_q[i].data);
                check({tag, "_keep"}, 64'(g[i].keep), 64'(exp_q[i].keep));
                check({tag, "_last"}, 64'(g[i].last), 64'(exp_q[i].last));
            end
        end
    endtask

    task automatic run_req(input int s, input logic [63:0] xv, input int len,
                           input bit exp_err, input int exp_nb, input string tag);
        int t;
        start_req(s, xv, len, tag, t);
        finish_req(s, xv, len, exp_err, exp_nb, tag, t);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          t;
        int          s;
        int          len;
        int          nb;
        bit          e;
        logic [63:0] xv;

        tbl[0]  = '{0, 64'h04030201,         4,  1'b0, 4};
        tbl[1]  = '{0, 64'h04030201,         6,  1'b0, 6};
        tbl[2]  = '{0, 64'h04030201,         3,  1'b1, 0};
        tbl[3]  = '{0, 64'h04030201,         0,  1'b1, 0};
        tbl[4]  = '{0, 64'h04030201,         9,  1'b1, 0};
        tbl[5]  = '{1, 64'h04030201,         6,  1'b0, 2};
        tbl[6]  = '{1, 64'h0102030405060708, 8,  1'b0, 2};
        tbl[7]  = '{0, 64'h0102030405060708, 8,  1'b0, 8};
        tbl[8]  = '{1, 64'h00030201,         3,  1'b0, 1};
        tbl[9]  = '{1, 64'h0100000000,       5,  1'b0, 2};
        tbl[10] = '{0, 64'h100,              1,  1'b1, 0};
        tbl[11] = '{1, 64'h04030201,         15, 1'b1, 0};

        // Reset, with a request offered to dut4 that reset must override.
        reset = 1'b1;
        drive(0, 1'b0, 64'd0, 0);
        drive(1, 1'b1, 64'd1, 1);
        if1.out_ready = 1'b1;
        if4.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1, 1'b0, 64'd0, 0);
        check("rst1_in_ready",  64'(if1.in_ready),  64'd1);
        check("rst1_out_valid", 64'(if1.out_valid), 64'd0);
        check("rst1_out_last",  64'(if1.out_last),  64'd0);
        check("rst1_out_keep",  64'(if1.out_keep),  64'd0);
        check("rst1_out_data",  64'(if1.out_data),  64'd0);
        check("rst1_err",       64'(if1.err),       64'd0);
        check("rst4_in_ready",  64'(if4.in_ready),  64'd1);
        check("rst4_out_valid", 64'(if4.out_valid), 64'd0);
        check("rst4_out_keep",  64'(if4.out_keep),  64'd0);
        check("rst4_out_data",  64'(if4.out_data),  64'd0);

        for (int i = 0; i < 12; i++) begin
            run_req(tbl[i].sel, tbl[i].x, tbl[i].len, tbl[i].err, tbl[i].nb,
                    $sformatf("vec%0d", i));
        end

        // Consumer stalls for three cycles while octet 03 is on the bus.
        manual = 1'b1;
        if1.out_ready = 1'b1;
        start_req(0, 64'h04030201, 4, "stall", t);
        repeat (2) @(posedge clk);
        #1;
        check("stall_b1", 64'(if1.out_data), 64'h04);
        @(posedge clk);
        #1;
        if1.out_ready = 1'b0;
        repeat (3) begin
            check("stall_b2_data",  64'(if1.out_data),  64'h03);
            check("stall_b2_valid", 64'(if1.out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        if1.out_ready = 1'b1;
        finish_req(0, 64'h04030201, 4, 1'b0, 4, "stall", t);
        manual = 1'b0;

        // Reset lands while beat 2 is on the bus.
        start_req(0, 64'h04030201, 4, "abort", t);
        repeat (3) @(posedge clk);
        #1;
        check("abort_b2", 64'(if1.out_data), 64'h03);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_out_valid", 64'(if1.out_valid), 64'd0);
        check("abort_in_ready",  64'(if1.in_ready),  64'd1);
        check("abort_out_data",  64'(if1.out_data),  64'd0);
        got0.delete();
        err_cnt[0] = 0;
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_beats", 64'(got0.size()), 64'd0);
        check("abort_no_err",   64'(err_cnt[0]),  64'd0);
        run_req(0, 64'h0A0B0C0D, 4, 1'b0, 4, "post_abort");

        // Random requests with a randomly stalling consumer.
        rnd_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            s   = int'($urandom_range(0, 1));
            len = int'($urandom_range(0, 9));
            xv  = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0 && len < 8) xv = xv & ((64'd1 << (8 * len)) - 64'd1);
            e  = model_err(xv, len);
            nb = e ? 0 : (len + ((s == 0) ? 1 : 4) - 1) / ((s == 0) ? 1 : 4);
            run_req(s, xv, len, e, nb, $sformatf("rnd%0d", i));
        end
        rnd_rdy = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2osp_stream.md
I2OSP_STREAM -- requirements
Module: i2osp_stream

Interface
REQ-001 SHALL have parameter WIDTH, 2048, integer input width in bits; multiple of 8, at least 16.
REQ-002 SHALL have parameter BPB, 1, octets per output beat; one of 1, 2, 4 or 8; divides WIDTH/8.
REQ-003 SHALL derive local LEN_W = $clog2(WIDTH/8 + 1).
REQ-004 SHALL have port clk, input, 1, single clock; all logic on posedge clk.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, request offered.
REQ-007 SHALL have port in_ready, output, 1, request accepted when in_valid && in_ready.
REQ-008 SHALL have port x, input, WIDTH, nonnegative integer to convert.
REQ-009 SHALL have port xlen, input, LEN_W, requested octet-string length.
REQ-010 SHALL have port out_valid, output, 1, out_data/out_keep/out_last valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts beat when out_valid && out_ready.
REQ-012 SHALL have port out_data, output, 8*BPB, octets; first octet in lane [8*BPB-1 -: 8].
REQ-013 SHALL have port out_keep, output, BPB, lane-valid mask; MSB = first lane.
REQ-014 SHALL have port out_last, output, 1, final beat of string.
REQ-015 SHALL have port err, output, 1, one-cycle pulse: request rejected.

Function
REQ-016 SHALL implement FSM IDLE -> CHECK -> STREAM -> IDLE, and CHECK -> ERR -> IDLE.
REQ-017 SHALL assert in_ready only in IDLE; on accept, register x and xlen, go to CHECK.
REQ-018 In CHECK, SHALL reject if xlen == 0, xlen > WIDTH/8, or any bit of x at index >= 8*xlen is 1 (x >= 256^xlen).
REQ-019 ERR SHALL last exactly one cycle with err=1, emit no beats, then return to IDLE.
REQ-020 Otherwise STREAM SHALL emit ceil(xlen/BPB) beats, big-endian: octet k (k=0..xlen-1) = bits [8*(xlen-1-k) +: 8] of x.
REQ-021 First out_valid SHALL occur 2 cycles after the accept edge (accept at edge t, out_valid high after edge t+2).
REQ-022 Beat advances only on out_valid && out_ready; while out_ready is low, out_data/out_keep/out_last SHALL hold stable.
REQ-023 out_keep SHALL be all-ones except final beat, which has its top (xlen mod BPB) bits set when nonzero; unkept lanes drive 0.
REQ-024 out_last SHALL be high only on final beat; after its handshake, FSM returns to IDLE and in_ready rises next cycle.
REQ-025 No back-to-back overlap: a new request is not accepted while CHECK/STREAM/ERR is active.
REQ-026 Octet counter SHALL be LEN_W bits and never wrap; xlen = WIDTH/8 streams the full word.

Reset
REQ-027 On reset, SHALL enter IDLE; after the edge: in_ready=1, out_valid=0, out_last=0, out_keep=0, out_data=0, err=0.
REQ-028 Reset mid-CHECK/STREAM/ERR SHALL abort immediately; no further beats or err pulse for the aborted request.
REQ-029 Reset SHALL override a simultaneous in_valid or out_ready handshake.

Structure
REQ-030 Package i2osp_pkg SHALL hold the FSM state enum and a len_width(WIDTH) function.
REQ-031 Range check (REQ-018) SHALL be sub-module i2osp_range_check (combinational, parameter WIDTH).
REQ-032 Shifting SHALL use a registered word shifted left by 8*BPB per beat; no WIDTH-wide mux per octet.

Verification
REQ-033 BPB=1, x=0x04030201, xlen=4 -> beats 04,03,02,01; out_last on 01; err never high.
REQ-034 BPB=1, x=0x04030201, xlen=6 -> 00,00,04,03,02,01; first out_valid 2 cycles after accept.
REQ-035 x=0x04030201, xlen=3; then xlen=0; then xlen=WIDTH/8+1 -> single err pulse each, zero beats, in_ready high next cycle.
REQ-036 BPB=4, x=0x04030201, xlen=6 -> beat1 0x00000403 keep 1111; beat2 0x02010000 keep 1100 with out_last.
REQ-037 BPB=1, out_ready low 3 cycles at beat 2 -> out_data held at 03 stable; no octet lost or duplicated.
REQ-038 Reset asserted during beat 2 of xlen=4 -> out_valid low after edge; in_ready=1; a following request streams correctly.
